// File: rtl/riscv_trace_retire_sched.sv
// In-order retirement scheduler for the instruction tracer: slots are allocated in program order,
// completed out of order by EX/LSU, and released to the tracer in order over valid/ready.
module riscv_trace_retire_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [31:0]      issue_pc_i,
  input  logic [31:0]      issue_instr_i,
  input  logic             issue_nowb_i,
  output logic [TAG_W-1:0] issue_tag_o,
  input  logic             cmpl0_valid_i,
  input  logic [TAG_W-1:0] cmpl0_tag_i,
  input  logic [31:0]      cmpl0_wdata_i,
  input  logic             cmpl1_valid_i,
  input  logic [TAG_W-1:0] cmpl1_tag_i,
  input  logic [31:0]      cmpl1_wdata_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [31:0]      trace_pc_o,
  output logic [31:0]      trace_instr_o,
  output logic [31:0]      trace_wdata_o,
  output logic [2:0]       trace_class_o,
  output logic             err_o
);

  typedef enum logic [1:0] {FREE = 2'd0, PEND = 2'd1, DONE = 2'd2} slot_st_e;

  slot_st_e        st      [DEPTH];
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     wdata_q [DEPTH];
  logic [2:0]      class_q [DEPTH];
  logic [TAG_W:0]  wr_ptr, rd_ptr;
  logic [TAG_W-1:0] wr_idx, rd_idx;
  logic            full, issue_fire, retire_fire, c0_ok, c1_ok, err_set;

  // First matching class wins; OP with funct7=0000001 is the M extension.
  function automatic logic [2:0] classify(input logic [31:0] ins);
    logic [2:0] c;
    c = 3'd7;
    case (ins[6:0])
      7'b0010011, 7'b0110111, 7'b0010111: c = 3'd0;
      7'b0110011: begin
        if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000) c = 3'd0;
        else if (ins[31:25] == 7'b0000001)                       c = 3'd3;
        else                                                     c = 3'd7;
      end
      7'b1100011, 7'b1101111, 7'b1100111: c = 3'd1;
      7'b0000011, 7'b0100011:             c = 3'd2;
      7'b1011011:                         c = 3'd3;
      7'b1110011, 7'b0001111:             c = 3'd4;
      7'b0000111, 7'b0100111, 7'b1010011,
      7'b1000011, 7'b1000111, 7'b1001011,
      7'b1001111:                         c = 3'd5;
      default:                            c = 3'd7;
    endcase
    return c;
  endfunction

  assign wr_idx        = wr_ptr[TAG_W-1:0];
  assign rd_idx        = rd_ptr[TAG_W-1:0];
  assign full          = (wr_ptr[TAG_W] != rd_ptr[TAG_W]) && (wr_idx == rd_idx);
  assign issue_ready_o = !full;
  assign issue_tag_o   = wr_idx;
  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign trace_valid_o = (st[rd_idx] == DONE);
  assign retire_fire   = trace_valid_o && trace_ready_i;

  // Port 0 wins a same-tag collision; anything not landing on a pending slot is an error.
  assign c0_ok   = cmpl0_valid_i && (st[cmpl0_tag_i] == PEND);
  assign c1_ok   = cmpl1_valid_i && (st[cmpl1_tag_i] == PEND) &&
                   !(cmpl0_valid_i && (cmpl0_tag_i == cmpl1_tag_i));
  assign err_set = (cmpl0_valid_i && !c0_ok) || (cmpl1_valid_i && !c1_ok);

  // Record fields are gated so an idle port reads as zero without resetting the payload.
  assign trace_pc_o    = trace_valid_o ? pc_q[rd_idx]    : '0;
  assign trace_instr_o = trace_valid_o ? instr_q[rd_idx] : '0;
  assign trace_wdata_o = trace_valid_o ? wdata_q[rd_idx] : '0;
  assign trace_class_o = trace_valid_o ? class_q[rd_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_o  <= 1'b0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (err_set) err_o <= 1'b1;
      if (retire_fire) begin
        st[rd_idx] <= FREE;
        rd_ptr     <= rd_ptr + 1'b1;
      end
      if (c0_ok) st[cmpl0_tag_i] <= DONE;
      if (c1_ok) st[cmpl1_tag_i] <= DONE;
      if (issue_fire) begin
        st[wr_idx] <= issue_nowb_i ? DONE : PEND;
        wr_ptr     <= wr_ptr + 1'b1;
      end
    end
  end

  // Payload storage: slots touched in one cycle are always distinct by state.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      pc_q[wr_idx]    <= issue_pc_i;
      instr_q[wr_idx] <= issue_instr_i;
      class_q[wr_idx] <= classify(issue_instr_i);
      wdata_q[wr_idx] <= '0;
    end
    if (c0_ok) wdata_q[cmpl0_tag_i] <= cmpl0_wdata_i;
    if (c1_ok) wdata_q[cmpl1_tag_i] <= cmpl1_wdata_i;
  end

endmodule

// File: tb/tb_riscv_trace_retire_sched.sv
// Scoreboard bench for riscv_trace_retire_sched: issued records are queued with hand-computed
// expectations and a negedge monitor checks every record the tracer accepts.
module tb_riscv_trace_retire_sched;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [2:0]  cls;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_i = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [31:0]      issue_pc_i = '0;
  logic [31:0]      issue_instr_i = '0;
  logic             issue_nowb_i = 1'b0;
  logic [TAG_W-1:0] issue_tag_o;
  logic             cmpl0_valid_i = 1'b0;
  logic [TAG_W-1:0] cmpl0_tag_i = '0;
  logic [31:0]      cmpl0_wdata_i = '0;
  logic             cmpl1_valid_i = 1'b0;
  logic [TAG_W-1:0] cmpl1_tag_i = '0;
  logic [31:0]      cmpl1_wdata_i = '0;
  logic             trace_valid_o;
  logic             trace_ready_i = 1'b1;
  logic [31:0]      trace_pc_o, trace_instr_o, trace_wdata_o;
  logic [2:0]       trace_class_o;
  logic             err_o;

  int   checks = 0;
  int   failures = 0;
  rec_t exp_q[$];

  riscv_trace_retire_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_pc_i(issue_pc_i), .issue_instr_i(issue_instr_i),
    .issue_nowb_i(issue_nowb_i), .issue_tag_o(issue_tag_o),
    .cmpl0_valid_i(cmpl0_valid_i), .cmpl0_tag_i(cmpl0_tag_i), .cmpl0_wdata_i(cmpl0_wdata_i),
    .cmpl1_valid_i(cmpl1_valid_i), .cmpl1_tag_i(cmpl1_tag_i), .cmpl1_wdata_i(cmpl1_wdata_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_wdata_o(trace_wdata_o), .trace_class_o(trace_class_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] wdata, input logic [2:0] cls);
    rec_t r;
    r.pc = pc; r.instr = instr; r.wdata = wdata; r.cls = cls;
    exp_q.push_back(r);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic nowb,
                       output logic [TAG_W-1:0] tag);
    issue_valid_i = 1'b1;
    issue_pc_i    = pc;
    issue_instr_i = instr;
    issue_nowb_i  = nowb;
    tag           = issue_tag_o;
    step();
    issue_valid_i = 1'b0;
    issue_nowb_i  = 1'b0;
  endtask

  // Monitor: every accepted record must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && trace_valid_o && trace_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record pc=0x%08h expected=none", trace_pc_o);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_pc", trace_pc_o, e.pc);
        chk("rec_instr", trace_instr_o, e.instr);
        chk("rec_wdata", trace_wdata_o, e.wdata);
        chk("rec_class", {29'd0, trace_class_o}, {29'd0, e.cls});
      end
    end
  end

  initial begin
    logic [TAG_W-1:0] t0, t1, t2, tx;

    step(); step();
    rst = 1'b0;
    chk("reset_valid", {31'd0, trace_valid_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);
    chk("reset_tag", {30'd0, issue_tag_o}, 32'd0);
    chk("reset_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("reset_pc", trace_pc_o, 32'd0);

    // ADDI completes one cycle after cmpl0.
    push(32'h80, 32'h00500093, 32'd5, 3'd0);
    issue(32'h80, 32'h00500093, 1'b0, t0);
    chk("addi_pending", {31'd0, trace_valid_o}, 32'd0);
    cmpl0_valid_i = 1'b1; cmpl0_tag_i = t0; cmpl0_wdata_i = 32'd5;
    step();
    cmpl0_valid_i = 1'b0;
    chk("addi_latency", {31'd0, trace_valid_o}, 32'd1);
    step();

    // Out-of-order completion, in-order retire on consecutive cycles.
    push(32'h84, 32'h0000A103, 32'hAA, 3'd2);
    push(32'h88, 32'h002081B3, 32'h11, 3'd0);
    push(32'h8C, 32'h00310233, 32'h22, 3'd0);
    issue(32'h84, 32'h0000A103, 1'b0, t0);
    issue(32'h88, 32'h002081B3, 1'b0, t1);
    issue(32'h8C, 32'h00310233, 1'b0, t2);
    cmpl0_valid_i = 1'b1; cmpl0_tag_i = t2; cmpl0_wdata_i = 32'h22;
    step();
    chk("ooo_hold1", {31'd0, trace_valid_o}, 32'd0);
    cmpl0_tag_i = t1; cmpl0_wdata_i = 32'h11;
    step();
    cmpl0_valid_i = 1'b0;
    chk("ooo_hold2", {31'd0, trace_valid_o}, 32'd0);
    cmpl1_valid_i = 1'b1; cmpl1_tag_i = t0; cmpl1_wdata_i = 32'hAA;
    step();
    cmpl1_valid_i = 1'b0;
    chk("ooo_ret0", {31'd0, trace_valid_o}, 32'd1);
    step();
    chk("ooo_ret1", {31'd0, trace_valid_o}, 32'd1);
    step();
    chk("ooo_ret2", {31'd0, trace_valid_o}, 32'd1);
    step();
    chk("ooo_drained", {31'd0, trace_valid_o}, 32'd0);

    // Full with tracer stalled: 5th issue is held until a slot frees.
    trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'hA0 + 32'(4 * i), 32'h00100093, 32'd0, 3'd0);
      issue(32'hA0 + 32'(4 * i), 32'h00100093, 1'b1, tx);
    end
    chk("full_ready", {31'd0, issue_ready_o}, 32'd0);
    chk("full_valid", {31'd0, trace_valid_o}, 32'd1);
    issue_valid_i = 1'b1; issue_pc_i = 32'hC0; issue_instr_i = 32'h00200093; issue_nowb_i = 1'b1;
    step();
    chk("full_held_ready", {31'd0, issue_ready_o}, 32'd0);
    chk("stall_pc_stable", trace_pc_o, 32'hA0);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    chk("after_retire_ready", {31'd0, issue_ready_o}, 32'd1);
    push(32'hC0, 32'h00200093, 32'd0, 3'd0);
    step();
    issue_valid_i = 1'b0; issue_nowb_i = 1'b0;
    chk("refull_ready", {31'd0, issue_ready_o}, 32'd0);
    trace_ready_i = 1'b1;
    repeat (4) step();
    chk("full_drained", {31'd0, trace_valid_o}, 32'd0);

    // nowb branch is valid next cycle; DIV classifies as mul/div.
    push(32'h100, 32'h00208463, 32'd0, 3'd1);
    issue(32'h100, 32'h00208463, 1'b1, tx);
    chk("beq_latency", {31'd0, trace_valid_o}, 32'd1);
    push(32'h104, 32'h0220C0B3, 32'd7, 3'd3);
    issue(32'h104, 32'h0220C0B3, 1'b0, t0);
    cmpl0_valid_i = 1'b1; cmpl0_tag_i = t0; cmpl0_wdata_i = 32'd7;
    step();
    cmpl0_valid_i = 1'b0;
    chk("div_valid", {31'd0, trace_valid_o}, 32'd1);
    step();
    chk("err_clean", {31'd0, err_o}, 32'd0);

    // Both ports on one tag: port 0 data wins, error flagged; free-slot completion ignored.
    push(32'h140, 32'h002081B3, 32'h1234, 3'd0);
    issue(32'h140, 32'h002081B3, 1'b0, t0);
    cmpl0_valid_i = 1'b1; cmpl0_tag_i = t0; cmpl0_wdata_i = 32'h1234;
    cmpl1_valid_i = 1'b1; cmpl1_tag_i = t0; cmpl1_wdata_i = 32'h5678;
    step();
    cmpl1_valid_i = 1'b0;
    chk("collide_err", {31'd0, err_o}, 32'd1);
    cmpl0_tag_i = t0 + 2'd1; cmpl0_wdata_i = 32'h99;
    step();
    cmpl0_valid_i = 1'b0;
    chk("free_cmpl_err", {31'd0, err_o}, 32'd1);
    step();
    chk("free_cmpl_ignored", {31'd0, trace_valid_o}, 32'd0);

    // Flush beats concurrent issue and completion.
    issue(32'h180, 32'h002081B3, 1'b0, t0);
    issue(32'h184, 32'h002081B3, 1'b0, t1);
    issue(32'h188, 32'h002081B3, 1'b0, t2);
    flush_i = 1'b1;
    issue_valid_i = 1'b1; issue_pc_i = 32'h18C; issue_instr_i = 32'h00100093; issue_nowb_i = 1'b1;
    cmpl0_valid_i = 1'b1; cmpl0_tag_i = t0; cmpl0_wdata_i = 32'h77;
    step();
    flush_i = 1'b0; issue_valid_i = 1'b0; issue_nowb_i = 1'b0; cmpl0_valid_i = 1'b0;
    chk("flush_valid", {31'd0, trace_valid_o}, 32'd0);
    chk("flush_tag", {30'd0, issue_tag_o}, 32'd0);
    chk("flush_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("flush_err_kept", {31'd0, err_o}, 32'd1);
    push(32'h200, 32'h00300093, 32'd0, 3'd0);
    issue(32'h200, 32'h00300093, 1'b1, tx);
    chk("post_flush_valid", {31'd0, trace_valid_o}, 32'd1);
    step();

    // Asynchronous reset clears the sticky error.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_err", {31'd0, err_o}, 32'd0);
    chk("async_rst_valid", {31'd0, trace_valid_o}, 32'd0);
    step();
    rst = 1'b0;
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
